// File: rtl/waw_pkg.sv
// Shared types and default configuration for the WAW kill tracker.
package waw_pkg;

    localparam int                     DEF_NUM_UNITS    = 9;
    localparam int                     DEF_RD_ADDR_W    = 5;
    localparam logic [DEF_NUM_UNITS-1:0] DEF_FP_UNIT_MASK = 9'b1_1111_1110;
    localparam int                     DEF_CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        KILLED = 2'd2
    } slot_state_e;

    // Snapshot of one slot at the default register address width.
    typedef struct packed {
        slot_state_e               state;
        logic [DEF_RD_ADDR_W-1:0]  rd;
    } slot_t;

    // A slot holds an in-flight instruction whether or not it was killed.
    function automatic logic slot_occupied(slot_state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/waw_slot.sv
// Lifecycle of one execution unit: which destination it will write and
// whether that write has been killed by a younger overwriting instruction.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no instruction in the unit
// BUSY   | instruction in flight, its result will be written back
// KILLED | instruction in flight, its result will be dropped on done
module waw_slot
    import waw_pkg::*;
#(
    parameter int RD_ADDR_W = DEF_RD_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic [RD_ADDR_W-1:0] issue_rd,
    input  logic                 done,
    input  logic                 kill,
    output slot_state_e          state,
    output logic [RD_ADDR_W-1:0] rd,
    output logic                 wb_suppress,
    output logic                 issue_err
);

    slot_state_e          state_nxt;
    logic [RD_ADDR_W-1:0] rd_nxt;

    // State and destination register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rd    <= '0;
        end else begin
            state <= state_nxt;
            rd    <= rd_nxt;
        end
    end

    // Next state; a done in the same cycle as an issue retires the old
    // result first, so the slot can reload without an error.
    always_comb begin
        state_nxt   = state;
        rd_nxt      = rd;
        wb_suppress = 1'b0;
        issue_err   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = BUSY;
                    rd_nxt    = issue_rd;
                end
            end
            BUSY, KILLED: begin
                wb_suppress = (state == KILLED) && done;
                if (done) begin
                    if (issue) begin
                        state_nxt = BUSY;
                        rd_nxt    = issue_rd;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    issue_err = issue;
                    if (kill && state == BUSY) begin
                        state_nxt = KILLED;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/waw_kill_tracker.sv
// Tracks in-flight destinations of multi-cycle units and kills a unit's
// writeback when a younger decoded instruction overwrites it unread.
module waw_kill_tracker
    import waw_pkg::*;
#(
    parameter int                   NUM_UNITS    = DEF_NUM_UNITS,
    parameter int                   RD_ADDR_W    = DEF_RD_ADDR_W,
    parameter logic [NUM_UNITS-1:0] FP_UNIT_MASK = DEF_FP_UNIT_MASK,
    parameter int                   CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [NUM_UNITS-1:0] issue_unit,
    input  logic [RD_ADDR_W-1:0] issue_rd,
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic                 new_valid,
    input  logic [RD_ADDR_W-1:0] new_rd,
    input  logic [RD_ADDR_W-1:0] new_rs1,
    input  logic [RD_ADDR_W-1:0] new_rs2,
    input  logic [RD_ADDR_W-1:0] new_rs3,
    input  logic                 new_is_r4,
    input  logic                 new_reg_write,
    input  logic                 new_fp_reg_write,
    input  logic                 no_exe_unit_dependency,
    output logic [NUM_UNITS-1:0] clear_rd,
    output logic [NUM_UNITS-1:0] wb_suppress,
    output logic [NUM_UNITS-1:0] slot_busy,
    output logic                 waw_stall,
    output logic [CNT_W-1:0]     kill_count,
    output logic                 proto_err
);

    slot_state_e          slot_state [NUM_UNITS];
    logic [RD_ADDR_W-1:0] slot_rd    [NUM_UNITS];
    logic [NUM_UNITS-1:0] issue_err;
    logic [NUM_UNITS-1:0] match;
    logic                 reads_rd;
    logic                 fp_write_ok;
    logic                 int_write_ok;
    logic [CNT_W:0]       kill_pop;
    logic [CNT_W:0]       kill_sum;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_slot
        waw_slot #(
            .RD_ADDR_W (RD_ADDR_W)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .issue       (issue_valid && issue_unit[i]),
            .issue_rd    (issue_rd),
            .done        (unit_done[i]),
            .kill        (clear_rd[i]),
            .state       (slot_state[i]),
            .rd          (slot_rd[i]),
            .wb_suppress (wb_suppress[i]),
            .issue_err   (issue_err[i])
        );
    end

    // Destination match against BUSY slots in the same register file; x0
    // writes never count because they have no architectural effect.
    always_comb begin
        reads_rd     = (new_rd == new_rs1) || (new_rd == new_rs2) ||
                       (new_is_r4 && (new_rd == new_rs3));
        fp_write_ok  = new_fp_reg_write && !new_reg_write;
        int_write_ok = new_reg_write && !new_fp_reg_write && (new_rd != '0);
        match        = '0;
        slot_busy    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            slot_busy[i] = slot_occupied(slot_state[i]);
            match[i]     = new_valid && (slot_state[i] == BUSY) &&
                           (slot_rd[i] == new_rd) &&
                           (FP_UNIT_MASK[i] ? fp_write_ok : int_write_ok);
        end
    end

    // Kill or stall; a slot retiring this cycle needs neither.
    always_comb begin
        clear_rd  = match & ~unit_done &
                    {NUM_UNITS{!reads_rd && no_exe_unit_dependency}};
        waw_stall = (|(match & ~unit_done)) &&
                    (reads_rd || !no_exe_unit_dependency);
    end

    // Number of kills this cycle and the saturating running total.
    always_comb begin
        kill_pop = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            kill_pop = kill_pop + (CNT_W+1)'(clear_rd[i]);
        end
        kill_sum = {1'b0, kill_count} + kill_pop;
    end

    // Kill counter and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            kill_count <= (kill_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                               : kill_sum[CNT_W-1:0];
            proto_err  <= proto_err || (|issue_err);
        end
    end

endmodule

// File: doc/waw_kill_tracker.md
Name: waw_kill_tracker

Overview:
- Parametrised successor to the combinational WAW clear decoder in the raw_waw_units group.
- Keeps registered per-unit state for every multi-cycle execution unit: destination register, register file (INT or FP), and a lifecycle FSM.
- When a newly decoded instruction overwrites an in-flight destination without reading it, the block kills that unit's writeback. When the new instruction does read it, the block raises a stall.
- Sits between decode/issue and the MEM/WB write-enable path.

Parameters:
- NUM_UNITS, 9: number of tracked execution units (slots).
- RD_ADDR_W, 5: register address width.
- FP_UNIT_MASK, 9'b1_1111_1110: bit i = 1 means unit i writes the FP file; 0 means INT file.
- CNT_W, 16: width of the saturating kill counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  an instruction enters a unit this cycle
- issue_unit  in  NUM_UNITS  one-hot target unit
- issue_rd  in  RD_ADDR_W  destination of the issued instruction
- unit_done  in  NUM_UNITS  unit i presents its result this cycle (1-cycle pulse)
- new_valid  in  1  decode-stage instruction valid
- new_rd, new_rs1, new_rs2, new_rs3  in  RD_ADDR_W each  decode-stage operand addresses
- new_is_r4  in  1  rs3 is meaningful
- new_reg_write  in  1  decode instruction writes the INT file
- new_fp_reg_write  in  1  decode instruction writes the FP file
- no_exe_unit_dependency  in  1  permission to kill this cycle
- clear_rd  out  NUM_UNITS  kill pulse per unit (combinational)
- wb_suppress  out  NUM_UNITS  drop unit i's write this cycle
- slot_busy  out  NUM_UNITS  slot i is BUSY or KILLED
- waw_stall  out  1  decode must hold
- kill_count  out  CNT_W  total kills, saturating
- proto_err  out  1  sticky: issue to a non-IDLE slot

Behaviour:
- Reset (asynchronous, rst_n = 0): every slot IDLE with rd = 0; kill_count = 0; proto_err = 0. All outputs read 0.
- Per-slot FSM: IDLE, BUSY, KILLED.
  - IDLE to BUSY: issue_valid and issue_unit[i]; latch issue_rd.
  - BUSY to IDLE: unit_done[i].
  - BUSY to KILLED: clear_rd[i] and not unit_done[i].
  - KILLED to IDLE: unit_done[i]; wb_suppress[i] = 1 in that same cycle.
- match[i]: slot i is BUSY, slot rd == new_rd, and new_valid. The file must also agree:
  - FP slot: new_fp_reg_write = 1 and new_reg_write = 0.
  - INT slot: new_reg_write = 1, new_fp_reg_write = 0, and new_rd != 0.
- reads_rd: new_rd is equal to rs1, to rs2, or to rs3 when new_is_r4 = 1.
- clear_rd[i] = match[i] and not reads_rd and no_exe_unit_dependency and not unit_done[i].
  - Derived from registered state only; the slot changes state at the next edge.
- waw_stall = 1 if any match[i] holds with reads_rd = 1, or with no_exe_unit_dependency = 0.
  - A kill blocked by unit_done does not stall: the result retires this cycle.
- Several slots may match the same rd; all of them are killed in the same cycle.
- KILLED slots are never matched again.
- Same slot, same cycle, issue and unit_done:
  - Slot BUSY or KILLED: the old result retires (suppressed if KILLED), then the slot reloads BUSY with issue_rd. proto_err is not set.
- Issue to a BUSY or KILLED slot without unit_done: the issue is ignored and proto_err sets. Only reset clears proto_err.
- unit_done on an IDLE slot: ignored, no wb_suppress.
- kill_count: adds popcount(clear_rd) every cycle and saturates at 2^CNT_W - 1.
- Reset mid-operation: all slots return to IDLE; any in-flight kill is forgotten.

Decomposition:
- Package waw_pkg:
  - typedef slot_state_e {IDLE, BUSY, KILLED}.
  - typedef slot_t {state, rd}.
  - Default-mask constants.
- Sub-module waw_slot: one FSM plus rd register, instantiated NUM_UNITS times by generate.
- Top level holds the match/stall reduction, popcount, counter and proto_err.

Test Plan:
1. Issue unit 1, rd = 5 (FP). Next cycle decode FP write rd = 5, rs1 = 2, rs2 = 3, no_exe_unit_dependency = 1 -> clear_rd = 9'b0_0000_0010. Slot 1 goes KILLED. Its later unit_done gives wb_suppress[1] = 1. kill_count = 1.
2. Same setup but rs2 = 5 -> clear_rd = 0, waw_stall = 1 until unit_done[1], then waw_stall = 0. No suppress.
3. INT slot 0 holding rd = 0, decode writes x0 -> no clear, no stall. Slot 0 with rd = 7 and decode FP write rd = 7 (file mismatch) -> no clear.
4. Match with unit_done[i] asserted in the same cycle -> clear_rd = 0, waw_stall = 0, result written, slot goes IDLE.
5. Issue to BUSY slot 3 without done -> proto_err = 1, slot rd unchanged. Issue plus done on slot 3 in the same cycle -> reload with the new rd, proto_err unchanged.
6. Preload kill_count near saturation via 0xFFFE kills, then a 2-slot simultaneous kill -> kill_count = 0xFFFF. Assert rst_n = 0 mid-KILLED -> all slot_busy = 0 and kill_count = 0 immediately.
